// File: rtl/aes_decrypt_iter.sv
// aes_decrypt_iter: iterative AES inverse cipher, one inverse round per clock.
//
// Optional feature macro: AES_DEC_ABORT_EN adds the abort input.
//
// Parameters:
//   N  - key width in bits (128/192/256)
//   Nr - number of rounds (10/12/14)
//   Nk - key length in 32-bit words (4/6/8)
//
// Ports:
//   clk       - sole clock, rising edge
//   reset     - asynchronous, active-high
//   in_valid  - ciphertext and key present
//   in_ready  - block can accept a new ciphertext
//   in        - ciphertext, byte 0 in bits [127:120]
//   key       - cipher key, same byte order
//   out_valid - plaintext valid, held until out_ready
//   out_ready - sink accepts plaintext
//   out       - plaintext
//   abort     - (AES_DEC_ABORT_EN only) drop the in-flight block, return to idle
//
// The round-key schedule is computed combinationally inside this file. The key
// register feeds the schedule used by the rounds. A second schedule, driven from
// the key input, supplies rk[Nr] for the whitening step at acceptance.
module aes_decrypt_iter #(
  parameter int unsigned N  = 128,
  parameter int unsigned Nr = 10,
  parameter int unsigned Nk = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in,
  input  logic [N-1:0]   key,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out
`ifdef AES_DEC_ABORT_EN
  ,
  input  logic           abort
`endif
);

  localparam int unsigned CntW    = $clog2(Nr);
  localparam int unsigned TotW    = 4 * (Nr + 1);
  localparam int unsigned KeyBits = 128 * (Nr + 1);

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  // GF(2^8) helpers, reduction polynomial 0x11B.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = ginv(b);
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return ginv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Full schedule, rk[0] in the top 128 bits, rk[Nr] in the bottom 128 bits.
  function automatic logic [KeyBits-1:0] key_expand(input logic [N-1:0] k);
    logic [31:0]        w [TotW];
    logic [31:0]        t;
    logic [7:0]         rc;
    logic [KeyBits-1:0] fk;
    rc = 8'h01;
    fk = '0;
    for (int i = 0; i < int'(Nk); i++) begin
      w[i] = k[N-1-32*i -: 32];
    end
    for (int i = int'(Nk); i < int'(TotW); i++) begin
      t = w[i-1];
      if (i % int'(Nk) == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xt(rc);
      end else if (Nk > 6 && i % int'(Nk) == 4) begin
        t = subword(t);
      end
      w[i] = w[i-int'(Nk)] ^ t;
    end
    for (int i = 0; i < int'(TotW); i++) begin
      fk[KeyBits-1-32*i -: 32] = w[i];
    end
    return fk;
  endfunction

  // InvShiftRows then InvSubBytes; byte index is 4*column + row.
  function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  state_e             st_q, st_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [127:0]       blk_q, blk_d;
  logic [N-1:0]       key_q, key_d;
  logic [127:0]       out_q, out_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [KeyBits-1:0] fk_in;
  logic [KeyBits-1:0] fk_q;
  logic [127:0]       rk_cur;
  logic [127:0]       sr_sb;

  always_comb begin
    fk_in  = key_expand(key);
    fk_q   = key_expand(key_q);
    rk_cur = fk_q[KeyBits-1-128*cnt_q -: 128];
    sr_sb  = inv_sr_sb(blk_q);
  end

  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    key_d       = key_q;
    out_d       = out_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (st_q)
      StIdle: begin
        in_ready_d = 1'b1;
        // in_ready_q is low for the first idle cycle after reset.
        if (in_valid && in_ready_q) begin
          key_d      = key;
          blk_d      = in ^ fk_in[127:0];
          cnt_d      = CntW'(Nr - 1);
          st_d       = StRound;
          in_ready_d = 1'b0;
        end
      end
      StRound: begin
        if (cnt_q != '0) begin
          blk_d = inv_mix(sr_sb ^ rk_cur);
          cnt_d = cnt_q - 1'b1;
        end else begin
          // cnt_q == 0 selects rk[0]; last round has no InvMixColumns.
          out_d       = sr_sb ^ rk_cur;
          out_valid_d = 1'b1;
          st_d        = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          st_d        = StIdle;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: st_d = StIdle;
    endcase
`ifdef AES_DEC_ABORT_EN
    // Abort beats a simultaneous output handshake; out keeps its last value.
    if (abort && st_q != StIdle) begin
      st_d        = StIdle;
      out_d       = out_q;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q        <= StIdle;
      cnt_q       <= '0;
      blk_q       <= '0;
      key_q       <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      key_q       <= key_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
module tb_aes_decrypt_iter;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] blk_in;
  logic [255:0] key_b;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_w     [3];
`ifdef AES_DEC_ABORT_EN
  logic         abort     [3];
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb [256];
  int         nk_of [3] = '{4, 6, 8};

  always #5 clk = ~clk;

  aes_decrypt_iter #(.N(128), .Nr(10), .Nk(4)) u_dut128 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in(blk_in),
    .key(key_b[255:128]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out(out_w[0])
`ifdef AES_DEC_ABORT_EN
    , .abort(abort[0])
`endif
  );

  aes_decrypt_iter #(.N(192), .Nr(12), .Nk(6)) u_dut192 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in(blk_in),
    .key(key_b[255:64]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out(out_w[1])
`ifdef AES_DEC_ABORT_EN
    , .abort(abort[1])
`endif
  );

  aes_decrypt_iter #(.N(256), .Nr(14), .Nk(8)) u_dut256 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in(blk_in),
    .key(key_b), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out(out_w[2])
`ifdef AES_DEC_ABORT_EN
    , .abort(abort[2])
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return (b << 1) ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rot8(input logic [7:0] q, input int n);
    return (q << n) | (q >> (8 - n));
  endfunction

  // S-box table built by walking the multiplicative group with generator 3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rot8(q, 1) ^ rot8(q, 2) ^ rot8(q, 3) ^ rot8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  // Forward cipher; decrypting its output must give back the plaintext.
  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [255:0] k,
                                           input int nk);
    int          nr;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [7:0]  a [16];
    logic [7:0]  b [16];
    logic [7:0]  x0, x1, x2, x3;
    logic [127:0] ct;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk == 8 && i % 8 == 4) begin
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int j = 0; j < 16; j++) a[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int j = 0; j < 16; j++) b[j] = sb[a[j]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) a[4*c+r] = b[4*((c+r)%4)+r];
      if (rnd != nr) begin
        for (int c = 0; c < 4; c++) begin
          x0 = a[4*c]; x1 = a[4*c+1]; x2 = a[4*c+2]; x3 = a[4*c+3];
          a[4*c]   = xtime(x0) ^ xtime(x1) ^ x1 ^ x2 ^ x3;
          a[4*c+1] = x0 ^ xtime(x1) ^ xtime(x2) ^ x2 ^ x3;
          a[4*c+2] = x0 ^ x1 ^ xtime(x2) ^ xtime(x3) ^ x3;
          a[4*c+3] = xtime(x0) ^ x0 ^ x1 ^ x2 ^ xtime(x3);
        end
      end
      for (int j = 0; j < 16; j++) a[j] = a[j] ^ w[4*rnd + j/4][31-8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) ct[127-8*j -: 8] = a[j];
    return ct;
  endfunction

  // One full transaction on instance idx: accept, count latency, optional
  // backpressure for `hold` cycles, then output handshake.
  task automatic run_block(input int idx, input logic [255:0] k, input logic [127:0] ct,
                           input logic [127:0] pt, input bit toggle, input int hold);
    int lat;
    @(negedge clk);
    blk_in = ct;
    key_b  = k;
    in_valid[idx]  = 1'b1;
    out_ready[idx] = 1'b0;
    chk("ready_before_accept", 128'(in_ready[idx]), 128'd1);
    @(posedge clk);
    #1;
    in_valid[idx] = 1'b0;
    chk("ready_low_after_accept", 128'(in_ready[idx]), 128'd0);
    lat = 0;
    while (!out_valid[idx] && lat < 40) begin
      if (toggle) key_b = {$urandom, $urandom, $urandom, $urandom,
                           $urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 128'(lat), 128'(nk_of[idx] + 6));
    chk("plaintext", out_w[idx], pt);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid[idx] = 1'b1;
      blk_in = ~ct;
      @(posedge clk);
      #1;
      chk("hold_valid", 128'(out_valid[idx]), 128'd1);
      chk("hold_out", out_w[idx], pt);
      chk("hold_ready", 128'(in_ready[idx]), 128'd0);
    end
    @(negedge clk);
    in_valid[idx]  = 1'b0;
    out_ready[idx] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[idx] = 1'b0;
    chk("valid_cleared", 128'(out_valid[idx]), 128'd0);
    chk("ready_after_handshake", 128'(in_ready[idx]), 128'd1);
  endtask

  localparam logic [255:0] KeyC1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] CtC1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PtStd  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KeyB   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CtB    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PtB    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] Key192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [127:0] Ct192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] Key256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] Ct256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    logic [127:0] pt;
    logic [255:0] k;
    int           lat;
    bit           rose;
    build_sbox();
    reset  = 1'b1;
    blk_in = '0;
    key_b  = '0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0;
      out_ready[i] = 1'b0;
`ifdef AES_DEC_ABORT_EN
      abort[i] = 1'b0;
`endif
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_in_ready", 128'(in_ready[i]), 128'd0);
      chk("reset_out_valid", 128'(out_valid[i]), 128'd0);
      chk("reset_out", out_w[i], 128'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_waits_for_edge", 128'(in_ready[0]), 128'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk("ready_after_reset", 128'(in_ready[i]), 128'd1);

    // Known-answer vectors.
    run_block(0, KeyC1, CtC1, PtStd, 1'b0, 0);
    run_block(0, KeyB, CtB, PtB, 1'b1, 0);
    run_block(1, Key192, Ct192, PtStd, 1'b0, 0);
    run_block(2, Key256, Ct256, PtStd, 1'b1, 0);
    run_block(0, KeyC1, CtC1, PtStd, 1'b0, 5);

    // Reset in the middle of the rounds discards the block.
    @(negedge clk);
    blk_in = CtB;
    key_b  = KeyB;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midreset_in_ready", 128'(in_ready[0]), 128'd0);
    chk("midreset_out_valid", 128'(out_valid[0]), 128'd0);
    chk("midreset_out", out_w[0], 128'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("postreset_ready", 128'(in_ready[0]), 128'd1);
    chk("postreset_no_valid", 128'(out_valid[0]), 128'd0);
    run_block(0, KeyC1, CtC1, PtStd, 1'b0, 0);

    // Random blocks against the forward-cipher model.
    for (int idx = 0; idx < 3; idx++) begin
      for (int n = 0; n < 3; n++) begin
        pt = {$urandom, $urandom, $urandom, $urandom};
        k  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if (nk_of[idx] == 4) k[127:0] = '0;
        if (nk_of[idx] == 6) k[63:0] = '0;
        run_block(idx, k, aes_enc(pt, k, nk_of[idx]), pt, 1'b1, int'($urandom_range(0, 3)));
      end
    end

`ifdef AES_DEC_ABORT_EN
    // Abort mid-round: block dropped, out keeps the last delivered value.
    run_block(0, KeyB, CtB, PtB, 1'b0, 0);
    @(negedge clk);
    blk_in = CtC1;
    key_b  = KeyC1;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    abort[0] = 1'b1;
    @(posedge clk);
    #1;
    abort[0] = 1'b0;
    chk("abort_ready", 128'(in_ready[0]), 128'd1);
    chk("abort_no_valid", 128'(out_valid[0]), 128'd0);
    rose = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid[0]) rose = 1'b1;
    end
    chk("abort_never_valid", 128'(rose), 128'd0);
    chk("abort_out_kept", out_w[0], PtB);
    // Abort together with out_ready in DONE.
    @(negedge clk);
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("abort_done_latency", 128'(lat), 128'd10);
    @(negedge clk);
    abort[0]     = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    abort[0]     = 1'b0;
    out_ready[0] = 1'b0;
    chk("abort_done_valid", 128'(out_valid[0]), 128'd0);
    chk("abort_done_ready", 128'(in_ready[0]), 128'd1);
    chk("abort_done_out", out_w[0], PtStd);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
